// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: memory handshake
// structs, arbiter states and the round-robin winner selection.
package dmem_arbiter_pkg;

   localparam int unsigned DataWidth = 32;

   // Requester -> memory side of the valid/yumi handshake.
   typedef struct packed {
      logic [DataWidth-1:0] write_data;
      logic                 valid;
      logic                 wen;
      logic                 byte_not_word;
      logic                 yumi;
   } mem_in_s;

   // Memory -> requester side of the valid/yumi handshake.
   typedef struct packed {
      logic                 yumi;
      logic                 valid;
      logic [DataWidth-1:0] read_data;
   } mem_out_s;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_RESP
   } arb_state_e;

   // A lone requester always wins; on a tie the priority pointer decides.
   function automatic logic pick_winner(input logic v0, input logic v1,
                                        input logic prio);
      logic w;
      w = 1'b0;
      if (v0 && v1) begin
         w = prio;
      end else if (v1) begin
         w = 1'b1;
      end
      return w;
   endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Per-transaction watchdog: a saturating cycle counter that clears at the
// start of each transaction and a sticky error flag raised when the count
// reaches the timeout while a transaction is in flight.
module dmem_watchdog #(
   parameter int unsigned timeout_cycles_p = 255,
   parameter int unsigned cnt_width_p      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic run_i,
   output logic err_o
);

   localparam logic [cnt_width_p-1:0] Timeout = cnt_width_p'(timeout_cycles_p);

   logic [cnt_width_p-1:0] cnt_q;
   logic [cnt_width_p-1:0] cnt_d;
   logic                   err_q;
   logic                   err_d;

   // Next count and next error flag.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Gated by run_i so a count left at the timeout value after a
      // completed transaction cannot flag an error while idle.
      if (run_i && (cnt_q == Timeout)) begin
         err_d = 1'b1;
      end
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the core
// LD/ST path (requester 0) and the network data loader (requester 1).
// One transaction is outstanding at a time; a watchdog flags stalls.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned timeout_cycles_p = 255,
   parameter int unsigned cnt_width_p      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  mem_in_s     req0_i,
   input  logic [31:0] req0_addr_i,
   output mem_out_s    resp0_o,
   input  mem_in_s     req1_i,
   input  logic [31:0] req1_addr_i,
   output mem_out_s    resp1_o,
   output mem_in_s     to_mem_o,
   output logic [31:0] mem_addr_o,
   input  mem_out_s    from_mem_i,
   output logic        owner_o,
   output logic        busy_o,
   output logic        err_o
);

   arb_state_e  state_q, state_d;
   logic        owner_q, owner_d;
   logic        prio_q,  prio_d;

   logic        grant;
   logic        winner;
   logic        sel_idx;
   logic        start;
   mem_in_s     req_sel;
   logic [31:0] addr_sel;
   mem_out_s    resp_sel;

   // Arbitration and requester selection: the winner while idle, the
   // latched owner once a transaction is under way.
   always_comb begin
      winner   = pick_winner(req0_i.valid, req1_i.valid, prio_q);
      grant    = reset && (req0_i.valid || req1_i.valid);
      sel_idx  = (state_q == ARB_IDLE) ? winner : owner_q;
      req_sel  = sel_idx ? req1_i : req0_i;
      addr_sel = sel_idx ? req1_addr_i : req0_addr_i;
   end

   // Next-state and handshake routing.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      prio_d     = prio_q;
      start      = 1'b0;
      to_mem_o   = '0;
      mem_addr_o = '0;
      resp_sel   = '0;
      resp0_o    = '0;
      resp1_o    = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant) begin
               to_mem_o   = req_sel;
               mem_addr_o = addr_sel;
               owner_d    = winner;
               start      = 1'b1;
               // Zero-wait grant: an accept in the grant cycle skips ARB_REQ.
               if (from_mem_i.yumi) begin
                  resp_sel.yumi = 1'b1;
                  state_d       = ARB_RESP;
               end else begin
                  state_d = ARB_REQ;
               end
            end
         end
         ARB_REQ: begin
            if (!req_sel.valid) begin
               state_d = ARB_IDLE;
            end else begin
               to_mem_o   = req_sel;
               mem_addr_o = addr_sel;
               if (from_mem_i.yumi) begin
                  resp_sel.yumi = 1'b1;
                  state_d       = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            to_mem_o.yumi      = req_sel.yumi;
            resp_sel.valid     = from_mem_i.valid;
            resp_sel.read_data = from_mem_i.read_data;
            if (from_mem_i.valid && req_sel.yumi) begin
               state_d = ARB_IDLE;
               prio_d  = ~owner_q;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      if (sel_idx) begin
         resp1_o = resp_sel;
      end else begin
         resp0_o = resp_sel;
      end
   end

   // Arbiter state, owner and priority pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB_IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
      end
   end

   assign owner_o = owner_q;
   assign busy_o  = (state_q != ARB_IDLE);

   dmem_watchdog #(
      .timeout_cycles_p (timeout_cycles_p),
      .cnt_width_p      (cnt_width_p)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear_i (start),
      .run_i   (busy_o),
      .err_o   (err_o)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one task per scenario, inline checks.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   mem_in_s     req0, req1;
   logic [31:0] a0, a1;
   mem_out_s    resp0, resp1;
   mem_in_s     to_mem;
   logic [31:0] mem_addr;
   mem_out_s    from_mem;
   logic        owner, busy, err;

   int n_checks;
   int n_fail;

   mem_in_s  exp_i;
   mem_out_s exp_o;

   dmem_arbiter #(
      .timeout_cycles_p (4),
      .cnt_width_p      (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_i      (req0),
      .req0_addr_i (a0),
      .resp0_o     (resp0),
      .req1_i      (req1),
      .req1_addr_i (a1),
      .resp1_o     (resp1),
      .to_mem_o    (to_mem),
      .mem_addr_o  (mem_addr),
      .from_mem_i  (from_mem),
      .owner_o     (owner),
      .busy_o      (busy),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0 = '0; req1 = '0; a0 = '0; a1 = '0; from_mem = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0 || owner !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b err=%b owner=%b want 0 0 0", busy, err, owner);
      end
      n_checks++;
      if (to_mem !== '0 || mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mem: to_mem=%h addr=%h want 0 0", to_mem, mem_addr);
      end
      n_checks++;
      if (resp0 !== '0 || resp1 !== '0) begin
         n_fail++;
         $display("FAIL reset_resp: resp0=%h resp1=%h want 0 0", resp0, resp1);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_core_load();
      // cycle 0: request and accept together
      req0 = '0; req0.valid = 1'b1; a0 = 32'h10;
      from_mem = '0; from_mem.yumi = 1'b1;
      #1;
      exp_i = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
      n_checks++;
      if (to_mem !== exp_i || mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL load_req: to_mem=%h addr=%h want %h 10", to_mem, mem_addr, exp_i);
      end
      exp_o = '{yumi: 1'b1, valid: 1'b0, read_data: 32'h0};
      n_checks++;
      if (resp0 !== exp_o || resp1 !== '0) begin
         n_fail++;
         $display("FAIL load_accept: resp0=%h resp1=%h want %h 0", resp0, resp1, exp_o);
      end
      tick();
      // cycle 1: response
      req0 = '0; req0.yumi = 1'b1;
      from_mem = '0; from_mem.valid = 1'b1; from_mem.read_data = 32'hDEADBEEF;
      #1;
      exp_o = '{yumi: 1'b0, valid: 1'b1, read_data: 32'hDEADBEEF};
      n_checks++;
      if (resp0 !== exp_o || resp1 !== '0 || busy !== 1'b1 || owner !== 1'b0) begin
         n_fail++;
         $display("FAIL load_resp: resp0=%h resp1=%h busy=%b owner=%b want %h 0 1 0",
                  resp0, resp1, busy, owner, exp_o);
      end
      exp_i = '{write_data: 32'h0, valid: 1'b0, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b1};
      n_checks++;
      if (to_mem !== exp_i) begin
         n_fail++;
         $display("FAIL load_resp_mem: to_mem=%h want %h", to_mem, exp_i);
      end
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (busy !== 1'b0 || resp0 !== '0) begin
         n_fail++;
         $display("FAIL load_done: busy=%b resp0=%h want 0 0", busy, resp0);
      end
   endtask

   task automatic test_round_robin();
      logic w;
      do_reset();
      req0 = '0; req0.valid = 1'b1; req0.write_data = 32'h1111; a0 = 32'h100;
      req1 = '0; req1.valid = 1'b1; req1.write_data = 32'h2222; a1 = 32'h200;
      for (int i = 0; i < 3; i++) begin
         w = (i % 2 == 1);
         req0.yumi = 1'b0; req1.yumi = 1'b0;
         from_mem = '0; from_mem.yumi = 1'b1;
         #1;
         n_checks++;
         if (to_mem.write_data !== (w ? 32'h2222 : 32'h1111) ||
             mem_addr !== (w ? 32'h200 : 32'h100)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: data=%h addr=%h want winner %0d", i,
                     to_mem.write_data, mem_addr, w);
         end
         n_checks++;
         if ({resp1.yumi, resp0.yumi} !== (w ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rr_yumi%0d: yumi1/0=%b%b want winner %0d", i,
                     resp1.yumi, resp0.yumi, w);
         end
         tick();
         req0.yumi = 1'b1; req1.yumi = 1'b1;
         from_mem = '0; from_mem.valid = 1'b1; from_mem.read_data = 32'hA0 + 32'(i);
         #1;
         exp_o = '{yumi: 1'b0, valid: 1'b1, read_data: 32'hA0 + 32'(i)};
         n_checks++;
         if (owner !== w || (w ? resp1 : resp0) !== exp_o || (w ? resp0 : resp1) !== '0) begin
            n_fail++;
            $display("FAIL rr_resp%0d: owner=%b resp0=%h resp1=%h want owner %0d data %h",
                     i, owner, resp0, resp1, w, exp_o);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_net_store();
      req0 = '0; req0.write_data = 32'hCAFE; req0.wen = 1'b1; a0 = 32'h99;
      req1 = '0; req1.valid = 1'b1; req1.wen = 1'b1; req1.byte_not_word = 1'b1;
      req1.write_data = 32'hAB; a1 = 32'h3;
      from_mem = '0;
      #1;
      exp_i = '{write_data: 32'hAB, valid: 1'b1, wen: 1'b1, byte_not_word: 1'b1, yumi: 1'b0};
      n_checks++;
      if (to_mem !== exp_i || mem_addr !== 32'h3) begin
         n_fail++;
         $display("FAIL store_req: to_mem=%h addr=%h want %h 3", to_mem, mem_addr, exp_i);
      end
      tick();
      from_mem.yumi = 1'b1;
      #1;
      n_checks++;
      if (to_mem !== exp_i || mem_addr !== 32'h3 || owner !== 1'b1 ||
          resp1.yumi !== 1'b1 || resp0 !== '0) begin
         n_fail++;
         $display("FAIL store_accept: to_mem=%h addr=%h owner=%b y1=%b resp0=%h", to_mem,
                  mem_addr, owner, resp1.yumi, resp0);
      end
      tick();
      req1.valid = 1'b0; req1.yumi = 1'b1;
      from_mem = '0; from_mem.valid = 1'b1;
      #1;
      exp_i = '{write_data: 32'h0, valid: 1'b0, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b1};
      n_checks++;
      if (to_mem !== exp_i || resp1.valid !== 1'b1 || resp0 !== '0) begin
         n_fail++;
         $display("FAIL store_resp: to_mem=%h v1=%b resp0=%h want %h 1 0", to_mem,
                  resp1.valid, resp0, exp_i);
      end
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL store_done: busy=%b want 0", busy);
      end
   endtask

   task automatic test_withhold();
      req0 = '0; req0.valid = 1'b1; a0 = 32'h20;
      from_mem = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (to_mem.valid !== 1'b1 || mem_addr !== 32'h20 || resp0.yumi !== 1'b0 ||
             (c > 0 && owner !== 1'b0)) begin
            n_fail++;
            $display("FAIL hold%0d: valid=%b addr=%h yumi=%b owner=%b", c, to_mem.valid,
                     mem_addr, resp0.yumi, owner);
         end
         tick();
      end
      from_mem.yumi = 1'b1;
      #1;
      n_checks++;
      if (resp0.yumi !== 1'b1 || to_mem.valid !== 1'b1 || mem_addr !== 32'h20) begin
         n_fail++;
         $display("FAIL hold_accept: yumi=%b valid=%b addr=%h want 1 1 20", resp0.yumi,
                  to_mem.valid, mem_addr);
      end
      tick();
      req0 = '0; req0.yumi = 1'b1;
      from_mem = '0; from_mem.valid = 1'b1; from_mem.read_data = 32'h12345678;
      #1;
      exp_o = '{yumi: 1'b0, valid: 1'b1, read_data: 32'h12345678};
      n_checks++;
      if (resp0 !== exp_o) begin
         n_fail++;
         $display("FAIL hold_resp: resp0=%h want %h", resp0, exp_o);
      end
      tick();
      clear_inputs();
      tick();
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_done: busy=%b err=%b want 0 0", busy, err);
      end
   endtask

   task automatic test_withdraw();
      req1 = '0; req1.valid = 1'b1; req1.write_data = 32'h5151; a1 = 32'h50;
      from_mem = '0;
      tick();
      req1.valid = 1'b0;
      from_mem.yumi = 1'b1;
      #1;
      n_checks++;
      if (to_mem.valid !== 1'b0 || resp1 !== '0 || resp0 !== '0) begin
         n_fail++;
         $display("FAIL withdraw: valid=%b resp1=%h resp0=%h want 0 0 0", to_mem.valid,
                  resp1, resp0);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL withdraw_idle: busy=%b want 0", busy);
      end
      // Priority pointer must still favour requester 1 on a tie.
      req0 = '0; req0.valid = 1'b1; req0.write_data = 32'h0A0A; a0 = 32'h60;
      req1.valid = 1'b1;
      #1;
      n_checks++;
      if (resp1.yumi !== 1'b1 || resp0.yumi !== 1'b0 || to_mem.write_data !== 32'h5151) begin
         n_fail++;
         $display("FAIL withdraw_prio: y1=%b y0=%b data=%h want 1 0 5151", resp1.yumi,
                  resp0.yumi, to_mem.write_data);
      end
      tick();
      req0.valid = 1'b0; req1.valid = 1'b0; req1.yumi = 1'b1;
      from_mem = '0; from_mem.valid = 1'b1;
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_timeout();
      req1 = '0; req1.valid = 1'b1; a1 = 32'h40;
      from_mem = '0;
      #1;
      n_checks++;
      if (to_mem.valid !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_grant: valid=%b err=%b want 1 0", to_mem.valid, err);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_checks++;
         if (err !== (k >= 6) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_err%0d: err=%b busy=%b want %0d 1", k, err, busy, (k >= 6));
         end
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0 || owner !== 1'b0 || to_mem !== '0 ||
          mem_addr !== 32'h0 || resp0 !== '0 || resp1 !== '0) begin
         n_fail++;
         $display("FAIL to_reset: busy=%b err=%b owner=%b to_mem=%h addr=%h r0=%h r1=%h",
                  busy, err, owner, to_mem, mem_addr, resp0, resp1);
      end
      tick();
      clear_inputs();
      reset = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after: busy=%b err=%b want 0 0", busy, err);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      clear_inputs();
      test_reset();
      test_core_load();
      test_round_robin();
      test_net_store();
      test_withhold();
      test_withdraw();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
